// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the instruction/data memory port arbiter.
package cpu_defs;

    typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} mem_src_t;

    localparam int DEFAULT_OUTSTANDING  = 4;
    localparam int DEFAULT_STARVE_LIMIT = 8;

endpackage

// File: rtl/mem_port_arbiter_resp_order_fifo.sv
// In-order record of which requester issued each outstanding downstream transaction.
module resp_order_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = DEFAULT_OUTSTANDING,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  mem_src_t      push_src,
    input  logic          pop,
    output mem_src_t      head_src,
    output logic [PW:0]   count,
    output logic          full,
    output logic          empty
);

    mem_src_t        entries [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_src = entries[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= SRC_DATA;
            end
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_src;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the ICache refill port and the data port onto one sram-like master,
// returning each response to the requester that issued it.
module mem_port_arbiter
    import cpu_defs::*;
#(
    parameter int OUTSTANDING  = DEFAULT_OUTSTANDING,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic           lock_valid;
    mem_src_t       lock_owner;
    logic [SW-1:0]  streak;
    logic           starved;
    logic           grant_valid;
    mem_src_t       grant;
    logic           grant_req;
    logic           accept;
    logic           pop;
    mem_src_t       head_src;
    logic [PW:0]    fifo_count;
    logic           fifo_full;
    logic           fifo_empty;

    assign starved = inst_req && (streak == SW'(STARVE_LIMIT));

    // A locked owner keeps the grant so its address phase cannot change mid-handshake.
    always_comb begin
        grant_valid = 1'b0;
        grant       = SRC_DATA;
        if (lock_valid) begin
            grant_valid = 1'b1;
            grant       = lock_owner;
        end else if (data_req && !starved) begin
            grant_valid = 1'b1;
            grant       = SRC_DATA;
        end else if (inst_req) begin
            grant_valid = 1'b1;
            grant       = SRC_INST;
        end
    end

    assign grant_req    = grant_valid && ((grant == SRC_INST) ? inst_req : data_req);
    assign m_req        = resetn && grant_req && !fifo_full;
    assign accept       = m_req && m_addr_ok;
    assign inst_addr_ok = accept && (grant == SRC_INST);
    assign data_addr_ok = accept && (grant == SRC_DATA);

    always_comb begin
        m_wr    = 1'b0;
        m_size  = 2'b00;
        m_wstrb = 4'b0000;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        if (grant_valid && grant == SRC_DATA) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end else if (grant_valid) begin
            m_size  = inst_size;
            m_addr  = inst_addr;
        end
    end

    // Responses with nothing outstanding are dropped rather than misrouted.
    assign pop          = resetn && m_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (head_src == SRC_INST);
    assign data_data_ok = pop && (head_src == SRC_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    resp_order_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_order (
        .clk      (clk),
        .resetn   (resetn),
        .push     (accept),
        .push_src (grant),
        .pop      (pop),
        .head_src (head_src),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_owner <= SRC_DATA;
        end else if (accept) begin
            lock_valid <= 1'b0;
        end else if (m_req) begin
            lock_valid <= 1'b1;
            lock_owner <= grant;
        end
    end

    // Counts data wins while inst waits; saturates so inst is forced through.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak <= '0;
        end else if (!inst_req) begin
            streak <= '0;
        end else if (inst_addr_ok) begin
            streak <= '0;
        end else if (data_addr_ok && (streak != SW'(STARVE_LIMIT))) begin
            streak <= streak + 1'b1;
        end
    end

    stray_response_check : assert property (
        @(posedge clk) disable iff (!resetn) !(m_data_ok && fifo_empty)
    ) else $warning("mem_port_arbiter: m_data_ok ignored, no transaction outstanding");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with default parameters.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        @(negedge clk);
        tests++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_req got %0b expected 0", m_req); end
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("[TB] FAIL reset_addr_ok got %b expected 00", {inst_addr_ok, data_addr_ok}); end
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("[TB] FAIL reset_data_ok got %b expected 00", {inst_data_ok, data_data_ok}); end
        tick();
        inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_inst;
        inst_req = 1'b1; inst_addr = 32'h1FC0_0000; inst_size = 2'd2; m_addr_ok = 1'b1;
        @(negedge clk);
        tests++; if (m_req !== 1'b1 || m_addr !== 32'h1FC0_0000) begin failures++; $display("[TB] FAIL single_issue got req=%0b addr=%h expected 1 1fc00000", m_req, m_addr); end
        tests++; if ({m_wr, m_wstrb, m_size} !== 7'b0_0000_10) begin failures++; $display("[TB] FAIL single_fields got %b expected 0000010", {m_wr, m_wstrb, m_size}); end
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("[TB] FAIL single_addr_ok got %b expected 10", {inst_addr_ok, data_addr_ok}); end
        tick();
        inst_req = 1'b0; m_addr_ok = 1'b0;
        tick();
        m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL single_resp got ok=%b rdata=%h expected 10 deadbeef", {inst_data_ok, data_data_ok}, inst_rdata); end
        tick();
        m_data_ok = 1'b0;
        @(negedge clk);
        tests++; if (inst_data_ok !== 1'b0) begin failures++; $display("[TB] FAIL single_resp_end got %0b expected 0", inst_data_ok); end
        tick();
    endtask

    task automatic test_arbitration;
        inst_req = 1'b1; inst_addr = 32'h1FC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0010; data_size = 2'd2;
        m_addr_ok = 1'b1;
        @(negedge clk);
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01 || m_addr !== 32'h8000_0010) begin failures++; $display("[TB] FAIL arb_first got ok=%b addr=%h expected 01 80000010", {inst_addr_ok, data_addr_ok}, m_addr); end
        tick();
        data_req = 1'b0;
        @(negedge clk);
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'h1FC0_0004) begin failures++; $display("[TB] FAIL arb_second got ok=%b addr=%h expected 10 1fc00004", {inst_addr_ok, data_addr_ok}, m_addr); end
        tick();
        inst_req = 1'b0; m_addr_ok = 1'b0;
        m_data_ok = 1'b1; m_rdata = 32'h1111_1111;
        @(negedge clk);
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h1111_1111) begin failures++; $display("[TB] FAIL arb_resp_data got ok=%b rdata=%h expected 01 11111111", {inst_data_ok, data_data_ok}, data_rdata); end
        tick();
        m_rdata = 32'h2222_2222;
        @(negedge clk);
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h2222_2222) begin failures++; $display("[TB] FAIL arb_resp_inst got ok=%b rdata=%h expected 10 22222222", {inst_data_ok, data_data_ok}, inst_rdata); end
        tick();
        m_data_ok = 1'b0;
    endtask

    task automatic test_lock;
        inst_req = 1'b1; inst_addr = 32'h1FC0_0040; m_addr_ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++; if (m_req !== 1'b1 || m_addr !== 32'h1FC0_0040 || m_wr !== 1'b0 || inst_addr_ok !== 1'b0) begin failures++; $display("[TB] FAIL lock_hold%0d got req=%0b addr=%h wr=%0b ok=%0b expected 1 1fc00040 0 0", c, m_req, m_addr, m_wr, inst_addr_ok); end
            tick();
            data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0100;
            data_wdata = 32'hCAFE_F00D; data_wstrb = 4'b1111;
        end
        m_addr_ok = 1'b1;
        @(negedge clk);
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'h1FC0_0040) begin failures++; $display("[TB] FAIL lock_accept got ok=%b addr=%h expected 10 1fc00040", {inst_addr_ok, data_addr_ok}, m_addr); end
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        tests++; if (data_addr_ok !== 1'b1 || m_wr !== 1'b1 || m_wdata !== 32'hCAFE_F00D || m_wstrb !== 4'b1111) begin failures++; $display("[TB] FAIL lock_data_next got ok=%0b wr=%0b wdata=%h wstrb=%b expected 1 1 cafef00d 1111", data_addr_ok, m_wr, m_wdata, m_wstrb); end
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'b0000; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        @(negedge clk);
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("[TB] FAIL lock_resp_inst got %b expected 10", {inst_data_ok, data_data_ok}); end
        tick();
        @(negedge clk);
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("[TB] FAIL lock_resp_data got %b expected 01", {inst_data_ok, data_data_ok}); end
        tick();
        m_data_ok = 1'b0;
    endtask

    task automatic test_full;
        data_req = 1'b1; data_addr = 32'h8000_0200; m_addr_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++; if (data_addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL full_fill%0d got %0b expected 1", c, data_addr_ok); end
            tick();
        end
        @(negedge clk);
        tests++; if (m_req !== 1'b0 || data_addr_ok !== 1'b0) begin failures++; $display("[TB] FAIL full_block got req=%0b ok=%0b expected 0 0", m_req, data_addr_ok); end
        tick();
        m_data_ok = 1'b1;
        @(negedge clk);
        tests++; if (m_req !== 1'b0 || data_data_ok !== 1'b1) begin failures++; $display("[TB] FAIL full_pop got req=%0b data_ok=%0b expected 0 1", m_req, data_data_ok); end
        tick();
        m_data_ok = 1'b0;
        @(negedge clk);
        tests++; if (m_req !== 1'b1 || data_addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL full_refill got req=%0b ok=%0b expected 1 1", m_req, data_addr_ok); end
        tick();
        @(negedge clk);
        tests++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL full_again got %0b expected 0", m_req); end
        tick();
        data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++; if (data_data_ok !== 1'b1) begin failures++; $display("[TB] FAIL full_drain%0d got %0b expected 1", c, data_data_ok); end
            tick();
        end
        m_data_ok = 1'b0;
    endtask

    task automatic test_starvation;
        inst_req = 1'b1; inst_addr = 32'h1FC0_0080;
        data_req = 1'b1; data_addr = 32'h8000_0300; m_addr_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin failures++; $display("[TB] FAIL starve_data%0d got %b expected 01", c, {inst_addr_ok, data_addr_ok}); end
            tick();
            m_data_ok = 1'b1;
        end
        @(negedge clk);
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("[TB] FAIL starve_inst got %b expected 10", {inst_addr_ok, data_addr_ok}); end
        tick();
        @(negedge clk);
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin failures++; $display("[TB] FAIL starve_reset got %b expected 01", {inst_addr_ok, data_addr_ok}); end
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("[TB] FAIL starve_resp_inst got %b expected 10", {inst_data_ok, data_data_ok}); end
        tick();
        inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
        @(negedge clk);
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("[TB] FAIL starve_resp_last got %b expected 01", {inst_data_ok, data_data_ok}); end
        tick();
        m_data_ok = 1'b0;
    endtask

    task automatic test_reset_midflight;
        data_req = 1'b1; data_addr = 32'h8000_0400; m_addr_ok = 1'b1;
        tick();
        tick();
        data_req = 1'b0; inst_req = 1'b1; m_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        tests++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin failures++; $display("[TB] FAIL midreset_m_req got req=%0b ok=%0b expected 0 0", m_req, inst_addr_ok); end
        tick();
        resetn = 1'b1; inst_req = 1'b0; m_data_ok = 1'b1;
        @(negedge clk);
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("[TB] FAIL midreset_stray got %b expected 00", {inst_data_ok, data_data_ok}); end
        tick();
        m_data_ok = 1'b0; data_req = 1'b1; m_addr_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++; if (data_addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL midreset_fill%0d got %0b expected 1", c, data_addr_ok); end
            tick();
        end
        @(negedge clk);
        tests++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL midreset_full got %0b expected 0", m_req); end
        tick();
        data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        repeat (4) tick();
        m_data_ok = 1'b0;
        tick();
    endtask

    initial begin
        inst_req = 1'b0; inst_size = 2'd2; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'b0000;
        data_addr = 32'h0; data_wdata = 32'h0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
        resetn = 1'b0;
        #1;
        test_reset();
        test_single_inst();
        test_arbitration();
        test_lock();
        test_full();
        test_starvation();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
